// File: rtl/downcount_mmss.sv
// MM:SS BCD countdown timer with load/start/stop control and optional auto-reload on expiry.
// Count and preset are held as four BCD digits; Done and LoadErr are registered one-cycle pulses.
module downcount_mmss #(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        Load,
   input  logic [15:0] LoadValue,
   input  logic        Start,
   input  logic        Stop,
   output logic [3:0]  MinT,
   output logic [3:0]  MinU,
   output logic [3:0]  SecT,
   output logic [3:0]  SecU,
   output logic        Running,
   output logic        Expired,
   output logic        Done,
   output logic        LoadErr
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   state_t      state;
   logic [15:0] count;
   logic [15:0] preset;
   logic [15:0] dec_count;
   logic        dec_zero;
   logic        load_ok;
   logic        borrow_su;
   logic        borrow_st;
   logic        borrow_mu;

   assign load_ok = (LoadValue[15:12] <= 4'd9) && (LoadValue[11:8] <= 4'd9) &&
                    (LoadValue[7:4]   <= 4'd5) && (LoadValue[3:0]  <= 4'd9);

   // One-second decrement: each digit wraps and borrows from the next only when it is zero.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      dec_count = count;
      borrow_su = (count[3:0] == 4'd0);
      borrow_st = borrow_su && (count[7:4] == 4'd0);
      borrow_mu = borrow_st && (count[11:8] == 4'd0);
      dec_count[3:0] = borrow_su ? 4'd9 : count[3:0] - 4'd1;
      if (borrow_su) begin
         dec_count[7:4] = (count[7:4] == 4'd0) ? 4'd5 : count[7:4] - 4'd1;
      end
      if (borrow_st) begin
         dec_count[11:8] = (count[11:8] == 4'd0) ? 4'd9 : count[11:8] - 4'd1;
      end
      if (borrow_mu) begin
         dec_count[15:12] = count[15:12] - 4'd1;
      end
   end

   assign dec_zero = (dec_count == 16'h0000);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
         state   <= IDLE;
         count   <= 16'h0000;
         preset  <= 16'h0000;
         Done    <= 1'b0;
         LoadErr <= 1'b0;
      end else begin
         Done    <= 1'b0;
         LoadErr <= 1'b0;
         case (state)
            IDLE: begin
               if (Load) begin
                  if (load_ok) begin
                     count  <= LoadValue;
                     preset <= LoadValue;
                  end else begin
                     LoadErr <= 1'b1;
                  end
               end else if (Start && !Stop) begin
                  if (count == 16'h0000) begin
                     state <= EXPIRED;
                     Done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (Stop) begin
                  state <= PAUSE;
               end else if (Enable) begin
                  if (!dec_zero) begin
                     count <= dec_count;
                  end else begin
                     Done <= 1'b1;
                     if (AUTO_RELOAD && (preset != 16'h0000)) begin
                        count <= preset;
                     end else begin
                        count <= 16'h0000;
                        state <= EXPIRED;
                     end
                  end
               end
            end
            PAUSE, EXPIRED: begin
               if (Load) begin
                  if (load_ok) begin
                     count  <= LoadValue;
                     preset <= LoadValue;
                     state  <= IDLE;
                  end else begin
                     LoadErr <= 1'b1;
                  end
               end else if ((state == PAUSE) && Start && !Stop) begin
                  state <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign {MinT, MinU, SecT, SecU} = count;
   assign Running = (state == RUN);
   assign Expired = (state == EXPIRED);

endmodule

// File: tb/tb_downcount_mmss.sv
// Bench for downcount_mmss: one instance per AUTO_RELOAD setting sharing the same stimulus,
// checked every cycle against a seconds-based model plus hand-computed expectations.
module tb_downcount_mmss;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_EXP   = 3;

   logic        Clock;
   logic        Reset;
   logic        Enable;
   logic        Load;
   logic [15:0] LoadValue;
   logic        Start;
   logic        Stop;

   logic [15:0] cnt0, cnt1;
   logic        run0, run1, exp0, exp1, done0, done1, lerr0, lerr1;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt0 = 0;
   int done_cnt1 = 0;

   // Model state: remaining time in whole seconds, preset in seconds, symbolic state.
   int m_secs [2];
   int m_pre  [2];
   int m_st   [2];
   bit m_done [2];
   bit m_lerr [2];

   downcount_mmss #(.AUTO_RELOAD(1'b0)) dut0 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Load(Load), .LoadValue(LoadValue),
      .Start(Start), .Stop(Stop),
      .MinT(cnt0[15:12]), .MinU(cnt0[11:8]), .SecT(cnt0[7:4]), .SecU(cnt0[3:0]),
      .Running(run0), .Expired(exp0), .Done(done0), .LoadErr(lerr0)
   );

   downcount_mmss #(.AUTO_RELOAD(1'b1)) dut1 (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Load(Load), .LoadValue(LoadValue),
      .Start(Start), .Stop(Stop),
      .MinT(cnt1[15:12]), .MinU(cnt1[11:8]), .SecT(cnt1[7:4]), .SecU(cnt1[3:0]),
      .Running(run1), .Expired(exp1), .Done(done1), .LoadErr(lerr1)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m, ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic int to_secs(input logic [15:0] v);
      return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_secs[i] = 0;
         m_pre[i]  = 0;
         m_st[i]   = S_IDLE;
         m_done[i] = 1'b0;
         m_lerr[i] = 1'b0;
      end
   endtask

   // One clock edge of the timer, described in seconds rather than digits.
   task automatic model_step();
      bit valid;
      valid = (LoadValue[15:12] <= 9) && (LoadValue[11:8] <= 9) &&
              (LoadValue[7:4] <= 5) && (LoadValue[3:0] <= 9);
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         m_lerr[i] = 1'b0;
         if (m_st[i] == S_RUN) begin
            if (Stop) begin
               m_st[i] = S_PAUSE;
            end else if (Enable) begin
               m_secs[i] = m_secs[i] - 1;
               if (m_secs[i] == 0) begin
                  m_done[i] = 1'b1;
                  if (i == 1 && m_pre[i] != 0) m_secs[i] = m_pre[i];
                  else m_st[i] = S_EXP;
               end
            end
         end else if (Load) begin
            if (valid) begin
               m_secs[i] = to_secs(LoadValue);
               m_pre[i]  = m_secs[i];
               m_st[i]   = S_IDLE;
            end else begin
               m_lerr[i] = 1'b1;
            end
         end else if (Start && !Stop && m_st[i] != S_EXP) begin
            if (m_secs[i] == 0) begin
               m_st[i]   = S_EXP;
               m_done[i] = 1'b1;
            end else begin
               m_st[i] = S_RUN;
            end
         end
      end
   endtask

   // Drive one cycle's inputs, let one rising edge happen, then clear the pulses.
   task automatic step(input bit en, input bit ld, input logic [15:0] lv, input bit sta, input bit sto);
      Enable    = en;
      Load      = ld;
      LoadValue = lv;
      Start     = sta;
      Stop      = sto;
      @(posedge Clock);
      model_step();
      #1;
      Enable = 1'b0;
      Load   = 1'b0;
      Start  = 1'b0;
      Stop   = 1'b0;
   endtask

   // Asynchronous reset pulse placed between clock edges; outputs must clear without a clock.
   task automatic do_reset();
      #1;
      Reset = 1'b1;
      model_reset();
      #1;
      check("async_rst_cnt0", cnt0, 16'h0000);
      check("async_rst_cnt1", cnt1, 16'h0000);
      check("async_rst_run0", 16'(run0), 16'h0);
      check("async_rst_exp0", 16'(exp0), 16'h0);
      check("async_rst_done0", 16'(done0), 16'h0);
      check("async_rst_done1", 16'(done1), 16'h0);
      #1;
      Reset = 1'b0;
   endtask

   always @(negedge Clock) begin
      check("cmp_cnt0",  cnt0, to_bcd(m_secs[0]));
      check("cmp_run0",  16'(run0), 16'(m_st[0] == S_RUN));
      check("cmp_exp0",  16'(exp0), 16'(m_st[0] == S_EXP));
      check("cmp_done0", 16'(done0), 16'(m_done[0]));
      check("cmp_lerr0", 16'(lerr0), 16'(m_lerr[0]));
      check("cmp_cnt1",  cnt1, to_bcd(m_secs[1]));
      check("cmp_run1",  16'(run1), 16'(m_st[1] == S_RUN));
      check("cmp_exp1",  16'(exp1), 16'(m_st[1] == S_EXP));
      check("cmp_done1", 16'(done1), 16'(m_done[1]));
      check("cmp_lerr1", 16'(lerr1), 16'(m_lerr[1]));
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
   end

   initial begin
      int dc0;
      logic [15:0] exp_seq [4];
      logic [15:0] lv;
      Reset     = 1'b1;
      Enable    = 1'b0;
      Load      = 1'b0;
      LoadValue = 16'h0000;
      Start     = 1'b0;
      Stop      = 1'b0;
      model_reset();
      #2;
      check("rst_cnt0", cnt0, 16'h0000);
      check("rst_run0", 16'(run0), 16'h0);
      check("rst_exp0", 16'(exp0), 16'h0);
      check("rst_done0", 16'(done0), 16'h0);
      check("rst_lerr0", 16'(lerr0), 16'h0);
      #1;
      Reset = 1'b0;

      // 01:03 counts down through the minute boundary to expiry.
      step(0, 1, 16'h0103, 0, 0);
      check("ld_cnt0", cnt0, 16'h0103);
      check("ld_run0", 16'(run0), 16'h0);
      step(0, 0, 16'h0000, 1, 0);
      check("start_run0", 16'(run0), 16'h1);
      dc0 = done_cnt0;
      for (int k = 1; k <= 63; k++) begin
         step(1, 0, 16'h0000, 0, 0);
         if (k == 1)  check("dn_0102", cnt0, 16'h0102);
         if (k == 3)  check("dn_0100", cnt0, 16'h0100);
         if (k == 4)  check("dn_0059", cnt0, 16'h0059);
         if (k == 62) check("dn_0001", cnt0, 16'h0001);
         if (k == 62) check("dn_nodone", 16'(done0), 16'h0);
      end
      check("exp_cnt0", cnt0, 16'h0000);
      check("exp_exp0", 16'(exp0), 16'h1);
      check("exp_run0", 16'(run0), 16'h0);
      check("exp_done0", 16'(done0), 16'h1);
      check("reload_cnt1", cnt1, 16'h0103);
      check("reload_run1", 16'(run1), 16'h1);
      step(1, 0, 16'h0000, 1, 1);
      step(1, 0, 16'h0000, 1, 0);
      check("exp_hold_cnt0", cnt0, 16'h0000);
      check("exp_done_once", 16'(done_cnt0 - dc0), 16'd1);

      // Rejected loads leave count and state untouched.
      do_reset();
      step(0, 1, 16'h0960, 0, 0);
      check("bad_sect_lerr", 16'(lerr0), 16'h1);
      check("bad_sect_cnt", cnt0, 16'h0000);
      step(0, 1, 16'hA000, 0, 0);
      check("bad_mint_lerr", 16'(lerr0), 16'h1);
      step(0, 0, 16'h0000, 0, 0);
      check("lerr_pulse_end", 16'(lerr0), 16'h0);
      check("bad_idle_run", 16'(run0), 16'h0);
      check("bad_idle_exp", 16'(exp0), 16'h0);

      // Start at 00:00 expires at once; Load during RUN is ignored.
      step(0, 0, 16'h0000, 1, 0);
      check("zstart_exp0", 16'(exp0), 16'h1);
      check("zstart_done0", 16'(done0), 16'h1);
      check("zstart_exp1", 16'(exp1), 16'h1);
      step(0, 0, 16'h0000, 0, 0);
      check("zstart_done_end", 16'(done0), 16'h0);
      step(0, 1, 16'h0005, 0, 0);
      check("exp_load_cnt", cnt0, 16'h0005);
      check("exp_load_idle", 16'(exp0), 16'h0);
      step(0, 0, 16'h0000, 1, 0);
      step(0, 1, 16'h0009, 0, 0);
      check("run_load_cnt", cnt0, 16'h0005);
      check("run_load_lerr", 16'(lerr0), 16'h0);
      step(0, 1, 16'hFFFF, 0, 0);
      check("run_badload_lerr", 16'(lerr0), 16'h0);

      // Pause/resume around 10:00.
      do_reset();
      step(0, 1, 16'h1000, 0, 0);
      step(0, 0, 16'h0000, 1, 0);
      step(1, 0, 16'h0000, 0, 0);
      check("p_0959", cnt0, 16'h0959);
      step(1, 0, 16'h0000, 0, 1);
      check("p_stop_cnt", cnt0, 16'h0959);
      check("p_stop_run", 16'(run0), 16'h0);
      for (int k = 0; k < 3; k++) step(1, 0, 16'h0000, 0, 0);
      check("p_frozen", cnt0, 16'h0959);
      step(1, 0, 16'h0000, 1, 0);
      check("p_resume_run", 16'(run0), 16'h1);
      check("p_resume_cnt", cnt0, 16'h0959);
      step(1, 0, 16'h0000, 0, 0);
      check("p_0958", cnt0, 16'h0958);
      step(0, 0, 16'h0000, 0, 1);
      step(0, 0, 16'h0000, 1, 1);
      check("stop_over_start", 16'(run0), 16'h0);
      step(0, 1, 16'h0200, 1, 0);
      check("load_over_start_run", 16'(run0), 16'h0);
      check("load_over_start_cnt", cnt0, 16'h0200);

      // Auto-reload from a 00:02 preset.
      do_reset();
      step(0, 1, 16'h0002, 0, 0);
      step(0, 0, 16'h0000, 1, 0);
      exp_seq = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 16'h0000, 0, 0);
         check("ar_cnt1", cnt1, exp_seq[k]);
         check("ar_done1", 16'(done1), 16'(k % 2));
         check("ar_run1", 16'(run1), 16'h1);
      end
      check("ar_off_exp0", 16'(exp0), 16'h1);

      // Reset mid-RUN at 05:30 and with a Done pulse outstanding.
      do_reset();
      step(0, 1, 16'h0530, 0, 0);
      step(0, 0, 16'h0000, 1, 0);
      dc0 = done_cnt0;
      do_reset();
      for (int k = 0; k < 3; k++) step(1, 0, 16'h0000, 0, 0);
      check("rst_run_nodone", 16'(done_cnt0 - dc0), 16'd0);
      step(0, 1, 16'h0001, 0, 0);
      step(0, 0, 16'h0000, 1, 0);
      step(1, 0, 16'h0000, 0, 0);
      check("pend_done", 16'(done0), 16'h1);
      do_reset();
      step(0, 0, 16'h0000, 0, 0);
      check("pend_done_dropped", 16'(done0), 16'h0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         case ($urandom % 4)
            0: lv = 16'($urandom);
            1: lv = {8'h00, 4'($urandom % 6), 4'($urandom % 10)};
            2: lv = {4'h0, 4'($urandom % 3), 4'($urandom % 6), 4'($urandom % 10)};
            default: lv = {12'h000, 4'($urandom % 3)};
         endcase
         step(1'($urandom % 2), 1'($urandom % 20 == 0), lv,
              1'($urandom % 8 == 0), 1'($urandom % 16 == 0));
         if ($urandom % 500 == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/downcount_mmss.md
DOWNCOUNT_MMSS -- requirements
Module: downcount_mmss

Interface
REQ-001 Parameter: AUTO_RELOAD, default 0, meaning 1 = reload stored preset and keep running on expiry, 0 = stop at 00:00.
REQ-002 Reset  input  1  reset Reset, asynchronous, active-high.
REQ-003 Clock  input  1  clock Clock; all state changes on posedge.
REQ-004 Enable  input  1  one-second tick, single-cycle pulse; decrements the count only in RUN.
REQ-005 Load  input  1  single-cycle request to load LoadValue as the preset and current count.
REQ-006 LoadValue  input  16  BCD preset {MinT[15:12], MinU[11:8], SecT[7:4], SecU[3:0]}.
REQ-007 Start  input  1  single-cycle request to begin or resume counting.
REQ-008 Stop  input  1  single-cycle request to pause counting.
REQ-009 MinT, MinU, SecT, SecU  output  4 each  current count, BCD, registered.
REQ-010 Running  output  1  high while state is RUN.
REQ-011 Expired  output  1  high while state is EXPIRED.
REQ-012 Done  output  1  one-cycle pulse on each expiry event.
REQ-013 LoadErr  output  1  one-cycle pulse when a Load is rejected.

Function
REQ-014 FSM states: IDLE, RUN, PAUSE, EXPIRED; exactly one state active.
REQ-015 IDLE: Load loads; Start goes to RUN if count is not 00:00 and to EXPIRED with Done if count is 00:00.
REQ-016 RUN: Enable decrements the count by one second; Stop goes to PAUSE; Load is ignored and raises no LoadErr.
REQ-017 PAUSE: count frozen; Start returns to RUN; Load loads and goes to IDLE.
REQ-018 EXPIRED: count held at 00:00; Load loads and goes to IDLE; Start and Stop are ignored.
REQ-019 Load validity: every digit must be <= 9 and SecT must be <= 5; otherwise the load is rejected, LoadErr pulses, and count, preset and state are unchanged.
REQ-020 A valid Load writes both the count registers and an internal 16-bit preset register on the same edge.
REQ-021 Decrement borrow chain:
- SecU 0 -> 9 with borrow, else SecU - 1.
- SecT 0 -> 5 with borrow, else SecT - 1.
- MinU 0 -> 9 with borrow, else MinU - 1.
- MinT - 1 only on borrow.
REQ-022 Outputs are never outside BCD range; SecT is never > 5.
REQ-023 Expiry: the Enable edge that produces 00:00 in RUN also enters EXPIRED (AUTO_RELOAD=0) and asserts Done in the following cycle, for exactly one cycle.
REQ-024 AUTO_RELOAD=1: on the expiry edge the count is reloaded from the preset, the state stays RUN, and Done pulses once; a preset of 00:00 enters EXPIRED instead.
REQ-025 Priority within a cycle: Stop over Start; Load over Start (Start is dropped).
REQ-026 Enable coinciding with Stop in RUN does not decrement.
REQ-027 Enable coinciding with Start outside RUN does not decrement; the first decrement is on the next Enable.
REQ-028 Enable outside RUN has no effect.
REQ-029 Running and Expired are decoded from the registered state (Moore outputs).

Reset
REQ-030 Asserting Reset immediately forces:
- state IDLE;
- count 00:00 and preset 00:00;
- Running, Expired, Done and LoadErr to 0.
REQ-031 Reset asserted mid-RUN or mid-expiry discards any pending Done pulse.
REQ-032 After Reset deasserts, the first active edge is processed normally.

Verification
REQ-033 Load 0x0103, Start, 63 Enable pulses -> counts 01:02, 01:01, 01:00, 00:59 ... 00:00; Expired=1, one Done pulse, Running=0.
REQ-034 Load 0x0960 -> LoadErr pulses, count stays 00:00; Load 0xA000 -> LoadErr pulses; state remains IDLE throughout.
REQ-035 Load 0x1000, Start, 1 Enable -> 09:59; Stop together with Enable -> count stays 09:59 in PAUSE; further Enables -> no change; Start -> RUN.
REQ-036 AUTO_RELOAD=1, Load 0x0002, Start, 4 Enables -> 00:01, 00:02 (Done pulse), 00:01, 00:02 (Done pulse); Running stays 1.
REQ-037 Start with count 00:00 -> EXPIRED and one Done pulse; Load while in RUN -> ignored, no LoadErr.
REQ-038 Reset asserted asynchronously mid-RUN at 05:30 -> outputs 00:00 and state IDLE before the next Clock edge; no Done pulse afterwards.
